// File: rtl/register_bank.sv
// register_bank: NUM_REGS x WIDTH register file with FunSel ops, sticky wrap and zero flags, two read ports
module register_bank #(
  parameter int WIDTH = 16,
  parameter int NUM_REGS = 4,
  localparam int SEL_W = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [2:0]          FunSel,
  input  logic [WIDTH-1:0]    I,
  input  logic                WrapClr,
  input  logic [SEL_W-1:0]    OutASel,
  input  logic [SEL_W-1:0]    OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic [NUM_REGS-1:0] Wrap,
  output logic [NUM_REGS-1:0] Zero
);
  localparam int H = WIDTH / 2;
  localparam int SLOTS = 2 ** SEL_W;
  function automatic logic [WIDTH-1:0] op(input logic [WIDTH-1:0] q, input logic [2:0] fs, input logic [WIDTH-1:0] d);
    case (fs)
      3'b000:  op = q - 1'b1;
      3'b001:  op = q + 1'b1;
      3'b010:  op = d;
      3'b011:  op = '0;
      3'b100:  op = {{H{1'b0}}, d[H-1:0]};
      3'b101:  op = {q[WIDTH-1:H], d[H-1:0]};
      3'b110:  op = {d[H-1:0], q[H-1:0]};
      default: op = {{H{d[H-1]}}, d[H-1:0]};
    endcase
  endfunction
  // slots beyond NUM_REGS read as zero so out-of-range selects need no extra compare
  logic [WIDTH-1:0] q [SLOTS];
  for (genvar r = 0; r < SLOTS; r++) begin : g_reg
    if (r < NUM_REGS) begin : g_live
      logic [WIDTH-1:0] qr, nq;
      logic w, z, ev;
      assign nq = RegSel[r] ? op(qr, FunSel, I) : qr;
      assign ev = RegSel[r] && ((FunSel == 3'b001 && &qr) || (FunSel == 3'b000 && ~|qr));
      always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
          qr <= '0;
          w  <= 1'b0;
          z  <= 1'b1;
        end else begin
          qr <= nq;
          w  <= ev | (w & ~WrapClr);
          z  <= ~|nq;
        end
      assign q[r] = qr;
      assign Wrap[r] = w;
      assign Zero[r] = z;
    end else begin : g_pad
      assign q[r] = '0;
    end
  end
  assign OutA = q[OutASel];
  assign OutB = q[OutBSel];
endmodule

// File: doc/register_bank.md
# register_bank

Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits, replacing single fixed 16-bit registers in the datapath. Every register supports the 3-bit FunSel operation set, generalised to any even width, with two independent read ports. Per-register sticky wrap flags report increment/decrement roll-over, and registered zero flags report register contents. It sits between the ALU/memory result buses and the ALU operand muxes.

## Interface
- WIDTH, 16, register width in bits; even, ≥4; H = WIDTH/2 is the half-width.
- NUM_REGS, 4, number of registers; 2..16.
- SEL_W, $clog2(NUM_REGS), read-select width (derived; do not override).

- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately, independent of Clock.
- RegSel  in  NUM_REGS  write-enable mask; bit i enables register i; several bits may be set at once.
- FunSel  in  3  operation applied to every enabled register.
- I  in  WIDTH  write data, shared by all enabled registers.
- WrapClr  in  1  synchronous clear of all Wrap bits.
- OutASel  in  SEL_W  read port A select.
- OutBSel  in  SEL_W  read port B select.
- OutA  out  WIDTH  contents of register OutASel; combinational from stored state.
- OutB  out  WIDTH  contents of register OutBSel; combinational from stored state.
- Wrap  out  NUM_REGS  sticky roll-over flag per register.
- Zero  out  NUM_REGS  registered flag per register; 1 when that register holds 0.

## Operation
- FunSel encoding, applied to register i when RegSel[i]=1:
  - 000: Q ← Q−1, modulo 2^WIDTH.
  - 001: Q ← Q+1, modulo 2^WIDTH.
  - 010: Q ← I.
  - 011: Q ← 0.
  - 100: Q ← {H zeros, I[H−1:0]}.
  - 101: Q ← {Q[WIDTH−1:H], I[H−1:0]}.
  - 110: Q ← {I[H−1:0], Q[H−1:0]}. The low half of I goes into the high half of Q.
  - 111: Q ← {H copies of I[H−1], I[H−1:0]} (sign-extended low-half load).
- Register with RegSel[i]=0 holds its value; FunSel and I are ignored for it.
- Wrap[i] sets on the edge where register i is enabled and either:
  - FunSel=001 with Q=all-ones (result 0), or
  - FunSel=000 with Q=0 (result all-ones).
- Wrap[i] stays set until WrapClr or Reset.
- WrapClr=1 clears all Wrap bits on the edge. If a wrap event occurs for register i on the same edge, Wrap[i] ends at 1 (set wins).
- Zero[i] is updated every edge from the next value of register i: Zero[i] = (next Q_i == 0). It therefore always matches the stored Q_i.
- Read ports:
  - Pure muxes of stored Q; no bypass from I.
  - Both ports may select the same register.
  - A select ≥ NUM_REGS (non-power-of-two NUM_REGS) drives all-zero on that port.
- Arithmetic is unsigned wrap-around; no saturation.
- No X propagation from unselected registers.

## Timing
- Reset asserted: all Q = 0, Wrap = 0, Zero = all-ones, OutA = OutB = 0, asynchronously, with no clock edge required.
- Reset deasserted: first update occurs on the next rising Clock edge. An operation presented during the edge on which Reset is still high is discarded.
- Write latency is one cycle: a value written at edge k is visible on OutA/OutB (and on Zero/Wrap) immediately after edge k.
- Reads are combinational: changing OutASel/OutBSel changes the outputs in the same cycle.
- Back-to-back operations on the same register every cycle are supported (e.g. consecutive increments count 1 per cycle).
- Reset mid-sequence: all registers and flags clear at once; the operation in flight is lost.

## Test plan
- Reset then idle, WIDTH=16, NUM_REGS=4: all Out = 0x0000, Zero = 4'b1111, Wrap = 0. Then load R2 with I=0x1234 → OutA(sel 2) = 0x1234 after one edge; Zero = 4'b1011.
- R0 = 0xFFFF, FunSel=001 → R0 = 0x0000, Wrap[0]=1, Zero[0]=1. Next cycle, FunSel=000 on R1 (=0) with WrapClr=1 → R1 = 0xFFFF, Wrap = 4'b0010.
- R3 = 0xAB00, then FunSel=101 with I=0x55CD → 0xABCD. Then FunSel=110 with I=0x0012 → 0x12CD. Then FunSel=111 with I=0x0080 → 0xFF80. Then FunSel=100 with I=0xFF80 → 0x0080.
- RegSel=4'b1111, FunSel=010, I=0x00FF → all four registers = 0x00FF. Then RegSel=4'b0101, FunSel=001 → R0 = R2 = 0x0100, R1 = R3 = 0x00FF.
- Assert Reset asynchronously mid-cycle during an increment stream → outputs zero before the next edge; the first post-release edge with FunSel=001 gives value 1.
- NUM_REGS=3, OutBSel=3 → OutB = 0. Also WIDTH=8 sweep: 0xFF+1 → 0x00 with wrap set.
